// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one registered 8-bit ALU between two requesters
module alu_rr_arbiter #(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_valid,
  input  logic                  r1_valid,
  input  logic signed [W-1:0]   r0_a,
  input  logic signed [W-1:0]   r0_b,
  input  logic signed [W-1:0]   r1_a,
  input  logic signed [W-1:0]   r1_b,
  input  logic [1:0]            r0_op,
  input  logic [1:0]            r1_op,
  output logic                  r0_ready,
  output logic                  r1_ready,
  output logic                  r0_rvalid,
  output logic                  r1_rvalid,
  input  logic                  r0_rready,
  input  logic                  r1_rready,
  output logic signed [2*W-1:0] rdata,
  output logic signed [W-1:0]   alu_a,
  output logic signed [W-1:0]   alu_b,
  output logic [1:0]            alu_ctrl,
  input  logic signed [2*W-1:0] alu_out,
  output logic                  busy,
  output logic [15:0]           done_cnt
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, CAPT = 2'd2, RESP = 2'd3;
  logic [1:0] state, state_nx;
  logic last_grant, gnt_id, win1, acc, rsp_hs;
  // A lone valid wins; on a tie the requester not granted last time wins
  always_comb begin
    win1 = r1_valid & (~r0_valid | ~last_grant);
    r0_ready = (state == IDLE) & r0_valid & ~win1;
    r1_ready = (state == IDLE) & win1;
    acc = r0_ready | r1_ready;
    rsp_hs = (state == RESP) & (gnt_id ? r1_rready : r0_rready);
    state_nx = state == IDLE  ? (acc ? ISSUE : IDLE) :
               state == ISSUE ? CAPT :
               state == CAPT  ? RESP :
               (rsp_hs ? IDLE : RESP);
  end
  assign busy = state != IDLE;
  assign r0_rvalid = (state == RESP) & ~gnt_id;
  assign r1_rvalid = (state == RESP) & gnt_id;
  // Latch the winning request, capture the ALU result, count completed responses
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      gnt_id <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
      alu_ctrl <= '0;
      rdata <= '0;
      done_cnt <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        alu_a <= r1_ready ? r1_a : r0_a;
        alu_b <= r1_ready ? r1_b : r0_b;
        alu_ctrl <= r1_ready ? r1_op : r0_op;
        gnt_id <= r1_ready;
        last_grant <= r1_ready;
      end
      if (state == CAPT) rdata <= alu_out;
      if (rsp_hs) done_cnt <= done_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed checks of arbitration, sequencing, back-pressure, reset and wrap
module tb_alu_rr_arbiter;
  localparam int W = 8;
  logic clk = 0, rst = 1;
  logic r0_valid = 0, r1_valid = 0, r0_rready = 0, r1_rready = 0;
  logic [W-1:0] r0_a = 0, r0_b = 0, r1_a = 0, r1_b = 0;
  logic [1:0] r0_op = 0, r1_op = 0;
  logic r0_ready, r1_ready, r0_rvalid, r1_rvalid, busy;
  logic [2*W-1:0] rdata, alu_out = 0;
  logic [W-1:0] alu_a, alu_b;
  logic [1:0] alu_ctrl;
  logic [15:0] done_cnt;
  int checks = 0, passed = 0;

  alu_rr_arbiter #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r1_valid(r1_valid),
    .r0_a(r0_a), .r0_b(r0_b), .r1_a(r1_a), .r1_b(r1_b),
    .r0_op(r0_op), .r1_op(r1_op),
    .r0_ready(r0_ready), .r1_ready(r1_ready),
    .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .r0_rready(r0_rready), .r1_rready(r1_rready),
    .rdata(rdata), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    logic signed [15:0] sa, sb;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    case (op)
      2'b00: return sa * sb + 16'sd3;
      2'b01: return {a & b, a ^ b};
      2'b11: return (sa + sb) <<< 2;
      default: return ($signed(a) >>> 2) > $signed(b) ? 16'h0001 : 16'hFFFF;
    endcase
  endfunction

  always_ff @(posedge clk) alu_out <= alu_f(alu_a, alu_b, alu_ctrl);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic run_op(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input logic [15:0] exp, input string tag);
    int n;
    if (id) begin r1_valid = 1; r1_a = a; r1_b = b; r1_op = op; end
    else begin r0_valid = 1; r0_a = a; r0_b = b; r0_op = op; end
    n = 0;
    #0;
    while (!(id ? r1_ready : r0_ready) && n < 20) begin step; n++; end
    chk({tag, "_grant"}, 32'(n < 20), 1);
    step;
    if (id) r1_valid = 0; else r0_valid = 0;
    n = 0;
    while (!(id ? r1_rvalid : r0_rvalid) && n < 20) begin step; n++; end
    chk({tag, "_rvalid"}, 32'(n < 20), 1);
    chk({tag, "_rdata"}, rdata, exp);
    chk({tag, "_other"}, id ? r0_rvalid : r1_rvalid, 0);
    step;
  endtask

  initial begin
    int n;
    bit id;
    step; step;
    chk("rst_busy", busy, 0);
    chk("rst_ready", {r0_ready, r1_ready}, 0);
    chk("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
    chk("rst_alu", {alu_a, alu_b, alu_ctrl}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_cnt", done_cnt, 0);
    rst = 0;
    step;
    // single op, requester 0, cycle-by-cycle
    r0_rready = 1; r1_rready = 1;
    r0_valid = 1; r0_a = 8'd3; r0_b = 8'hFE; r0_op = 2'b00;
    #0;
    chk("c0_ready", {r0_ready, r1_ready}, 2'b10);
    chk("c0_busy", busy, 0);
    step;
    r0_valid = 0;
    chk("c1_busy", busy, 1);
    chk("c1_alu", {alu_a, alu_b, alu_ctrl}, {8'd3, 8'hFE, 2'b00});
    chk("c1_ready", r0_ready, 0);
    step;
    chk("c2_busy", busy, 1);
    chk("c2_rvalid", r0_rvalid, 0);
    step;
    chk("c3_rvalid", {r0_rvalid, r1_rvalid}, 2'b10);
    chk("c3_rdata", rdata, 16'hFFFD);
    chk("c3_busy", busy, 1);
    step;
    chk("c4_busy", busy, 0);
    chk("c4_rvalid", r0_rvalid, 0);
    chk("c4_cnt", done_cnt, 1);
    // requester 1 ops
    run_op(1, 8'h0F, 8'h3C, 2'b01, 16'h0C33, "r1_op01");
    run_op(1, 8'd100, 8'd50, 2'b11, 16'h0258, "r1_op11");
    chk("cnt3", done_cnt, 3);
    // continuous tie after reset: grants alternate 0,1,0,1
    rst = 1; step; rst = 0;
    r0_valid = 1; r0_a = 8'h80; r0_b = 8'hDF; r0_op = 2'b10;
    r1_valid = 1; r1_a = 8'd4; r1_b = 8'd5; r1_op = 2'b10;
    #0;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(r0_ready | r1_ready) && n < 20) begin step; n++; end
      chk("tie_one_ready", r0_ready ^ r1_ready, 1);
      chk("tie_grant", r1_ready, g % 2);
      id = r1_ready;
      step;
      n = 0;
      while (!(r0_rvalid | r1_rvalid) && n < 20) begin step; n++; end
      chk("tie_rid", {r0_rvalid, r1_rvalid}, id ? 2'b01 : 2'b10);
      chk("tie_rdata", rdata, id ? 16'hFFFF : 16'h0001);
      step;
    end
    r0_valid = 0; r1_valid = 0;
    step;
    // back-pressure on requester 0 with requester 1 waiting
    r0_rready = 0;
    r0_valid = 1; r0_a = 8'd3; r0_b = 8'hFE; r0_op = 2'b00;
    #0;
    chk("bp_grant", r0_ready, 1);
    step;
    r0_valid = 0;
    r1_valid = 1; r1_a = 8'h0F; r1_b = 8'h3C; r1_op = 2'b01;
    n = 0;
    while (!r0_rvalid && n < 20) begin step; n++; end
    for (int i = 0; i < 6; i++) begin
      chk("bp_rvalid", r0_rvalid, 1);
      chk("bp_rdata", rdata, 16'hFFFD);
      chk("bp_no_ready", r1_ready, 0);
      if (i == 5) r0_rready = 1;
      step;
    end
    chk("bp_next_grant", r1_ready, 1);
    step;
    r1_valid = 0;
    n = 0;
    while (!r1_rvalid && n < 20) begin step; n++; end
    chk("bp_r1_rdata", rdata, 16'h0C33);
    step;
    // reset during CAPT discards the op
    r0_valid = 1; r0_a = 8'd100; r0_b = 8'd50; r0_op = 2'b11;
    #0;
    chk("rc_grant", r0_ready, 1);
    step;
    r0_valid = 0;
    step;
    rst = 1;
    step;
    chk("rc_busy", busy, 0);
    chk("rc_rvalid", {r0_rvalid, r1_rvalid}, 0);
    chk("rc_alu", {alu_a, alu_b, alu_ctrl}, 0);
    chk("rc_rdata", rdata, 0);
    chk("rc_cnt", done_cnt, 0);
    rst = 0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      n += r0_rvalid;
      step;
    end
    chk("rc_no_rvalid", n, 0);
    r0_valid = 1; r0_a = 8'd3; r0_b = 8'hFE; r0_op = 2'b00;
    r1_valid = 1; r1_a = 8'd4; r1_b = 8'd5; r1_op = 2'b10;
    #0;
    chk("rc_tie", {r0_ready, r1_ready}, 2'b10);
    step;
    r0_valid = 0; r1_valid = 0;
    n = 0;
    while (!r0_rvalid && n < 20) begin step; n++; end
    chk("rc_rdata2", rdata, 16'hFFFD);
    step;
    // done_cnt wrap
    force dut.done_cnt = 16'hFFFF;
    step;
    release dut.done_cnt;
    step;
    chk("wrap_pre", done_cnt, 16'hFFFF);
    run_op(0, 8'h0F, 8'h3C, 2'b01, 16'h0C33, "wrap_op");
    chk("wrap_cnt", done_cnt, 16'h0000);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Two-port round-robin arbiter and sequencer that shares one instance of the team's 8-bit registered signed ALU between two independent requesters. Each requester presents an operand pair and a 2-bit opcode with a valid/ready handshake. The block latches the winning request and drives the ALU inputs. It captures the ALU result after the ALU's fixed one-cycle latency and returns the 16-bit result to the originating requester with a valid/ready handshake. It sits between the requesters and the ALU, which is its only consumer.

## Interface
- W, 8: operand width; result width is 2*W.
- clk  in  1  rising-edge clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- r0_valid, r1_valid  in  1  request valid, requester 0 / 1.
- r0_a, r0_b, r1_a, r1_b  in  W  signed operands.
- r0_op, r1_op  in  2  ALU opcode.
- r0_ready, r1_ready  out  1  request accepted this cycle when high with the matching valid.
- r0_rvalid, r1_rvalid  out  1  response valid.
- r0_rready, r1_rready  in  1  response accepted.
- rdata  out  2W  signed result; shared by both responders and meaningful only under the asserted rvalid.
- alu_a, alu_b  out  W  registered ALU operands.
- alu_ctrl  out  2  registered ALU opcode.
- alu_out  in  2W  ALU registered result.
- busy  out  1  high whenever state is not IDLE.
- done_cnt  out  16  count of completed responses; wraps.

## Operation
ALU contract (fixed; one-cycle registered latency):
- 00: A*B+3
- 01: {A&B, A^B}
- 11: (A+B)<<2, with operands sign-extended to 2W
- 10: (A>>>2 > B) ? 1 : -1

FSM states are IDLE, ISSUE, CAPT and RESP.
- IDLE:
  - The winner is the requester with valid high. If both are high, the winner is the one not granted last (last_grant).
  - Only the winner's ready is driven high. It is combinational, from the valid inputs and last_grant, and is only ever high in IDLE.
  - On a handshake: latch a/b/op into alu_a/alu_b/alu_ctrl, record the owner in gnt_id, update last_grant to the owner, and go to ISSUE.
  - With no valid input, stay in IDLE.
- ISSUE: the ALU samples its inputs at the end of this cycle. Go to CAPT unconditionally.
- CAPT: alu_out holds the result. Register it into rdata, set the owner's rvalid, and go to RESP.
- RESP:
  - Hold rdata and the owner's rvalid until that requester's rready is high.
  - On that handshake: clear rvalid, increment done_cnt (modulo 2^16) and go to IDLE.
  - The non-owner's rready is ignored.
- alu_a, alu_b and alu_ctrl hold their last values outside ISSUE. They change only on a request handshake.
- Requester inputs are don't-care after acceptance. A dropped or changed valid has no effect on the operation in flight.
- Per-requester ordering is in order. At most one operation is outstanding in total.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1 (requester 0 wins the first tie).
  - all ready/rvalid outputs = 0, busy = 0.
  - rdata, alu_a, alu_b, alu_ctrl, done_cnt = 0.
- Cycle n: request handshake in IDLE.
- Cycle n+1: ISSUE; ALU inputs are valid.
- Cycle n+2: CAPT; alu_out is valid.
- Cycle n+3: rvalid high; response at the earliest.
- If rready is already high in n+3, state returns to IDLE in n+4. Peak throughput is one operation per 4 cycles.
- Back-pressure: every cycle rready is low adds one cycle in RESP. rdata stays stable throughout.
- Simultaneous valid from both requesters in IDLE: exactly one ready is high. The loser keeps waiting and wins the next IDLE arbitration if it is still valid.
- A new request is not accepted in the same cycle as a response handshake. It is accepted next cycle in IDLE.
- rst asserted in any state takes effect at the next edge with the reset values above. Any in-flight result is discarded and no rvalid is produced for it.
- done_cnt wraps from 16'hFFFF to 16'h0000.

## Test plan
- Single op, requester 0, op 00, A=3, B=-2, rready held high -> r0_ready high in cycle 0; r0_rvalid high in cycle 3 with rdata 16'hFFFD; done_cnt=1; busy high for cycles 1-3.
- Requester 1, op 01, A=8'h0F, B=8'h3C -> rdata 16'h0C33 on r1_rvalid, and r0_rvalid stays 0. Then op 11, A=100, B=50 -> rdata 16'h0258.
- Both requesters valid continuously after reset, requester 0 with op 10 (A=-128, B=-33) and requester 1 with op 10 (A=4, B=5) -> grants alternate 0,1,0,1. Requester 0 responses are 16'h0001 and requester 1 responses are 16'hFFFF.
- Back-pressure: r0_rready low for 5 cycles after rvalid -> rvalid and rdata stable for 6 cycles. No new ready is issued during RESP. Next grant occurs in the cycle after the handshake.
- Reset in CAPT -> next cycle all outputs are at reset values and no rvalid is seen for that op. A subsequent tie grants requester 0.
- Force done_cnt to 16'hFFFF, or run 65536 ops, then complete one op -> done_cnt reads 16'h0000.
